// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Holds the controller state encoding and the default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sam_datapath.sv
// Operand, accumulator and counter registers for the shift-and-add multiplier.
// Also holds the magnitude, add/shift and result-negation logic, plus the product register.
module sam_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int EARLY_TERM = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 last
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mplier_next;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    result;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             neg;

    // The most negative operand negates onto itself, which reads correctly as an unsigned magnitude.
    always_comb begin
        a_mag       = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag       = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        addend      = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
        acc_next    = acc + addend;
        mplier_next = mplier >> 1;
        cnt_next    = cnt + CW'(1);
        result      = neg ? (~acc_next + PW'(1)) : acc_next;
        last        = (cnt_next == CW'(WIDTH)) ||
                      ((EARLY_TERM != 0) && (mplier_next == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            prod   <= '0;
        end else if (load) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            acc    <= acc_next;
            mplier <= mplier_next;
            cnt    <= cnt_next;
            if (last) begin
                prod <= result;
            end
        end
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier: IDLE/RUN/DONE controller around sam_datapath.
// One partial product per RUN cycle, with optional early exit once the multiplier runs out of ones.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int EARLY_TERM = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 valid,
    output logic                 busy
);

    state_t state;
    logic   accept;
    logic   step;
    logic   last;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign step   = (state == RUN);

    sam_datapath #(
        .WIDTH      (WIDTH),
        .EARLY_TERM (EARLY_TERM)
    ) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .load        (accept),
        .step        (step),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .prod        (prod),
        .last        (last)
    );

    // Start is only honoured outside RUN, so a request during a multiply is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult: one early-terminating and one full-iteration instance, WIDTH=4.
// Expected products and latencies are hand-computed constants.
module tb_shift_add_mult;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       signed_mode = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [7:0] prod;
    logic       valid;
    logic       busy;

    logic       start2 = 1'b0;
    logic       signed_mode2 = 1'b0;
    logic [3:0] a2 = '0;
    logic [3:0] b2 = '0;
    logic [7:0] prod2;
    logic       valid2;
    logic       busy2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_add_mult #(.WIDTH(4), .EARLY_TERM(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .prod        (prod),
        .valid       (valid),
        .busy        (busy)
    );

    shift_add_mult #(.WIDTH(4), .EARLY_TERM(0)) dut_full (
        .clk         (clk),
        .reset       (reset),
        .start       (start2),
        .signed_mode (signed_mode2),
        .a           (a2),
        .b           (b2),
        .prod        (prod2),
        .valid       (valid2),
        .busy        (busy2)
    );

    // Accepts one operation, scrambles the inputs afterwards, and reports latency, product and busy cycles.
    task automatic do_mult(input bit sel, input logic [3:0] av, input logic [3:0] bv, input logic sm,
                           output int lat, output logic [7:0] p, output int busy_cycles, output int overlap);
        @(negedge clk);
        if (sel) begin a2 = av; b2 = bv; signed_mode2 = sm; start2 = 1'b1; end
        else     begin a  = av; b  = bv; signed_mode  = sm; start  = 1'b1; end
        @(posedge clk);
        #1;
        start = 1'b0; start2 = 1'b0;
        a = ~av; b = ~bv; a2 = ~av; b2 = ~bv;
        signed_mode = ~sm; signed_mode2 = ~sm;
        lat = 0; p = '0; busy_cycles = 0; overlap = 0;
        for (int i = 1; i <= 20; i++) begin
            if (sel ? busy2 : busy) busy_cycles++;
            @(posedge clk);
            #1;
            if ((sel ? valid2 : valid) && (sel ? busy2 : busy)) overlap++;
            if (sel ? valid2 : valid) begin
                lat = i;
                p = sel ? prod2 : prod;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        start2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (prod !== 8'h00) begin failures++; $display("[TB] FAIL reset_prod got=%h exp=00", prod); end
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        start = 1'b0;
        start2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_unsigned();
        int lat, bc, ov;
        logic [7:0] p;
        do_mult(1'b0, 4'd13, 4'd11, 1'b0, lat, p, bc, ov);
        checks++; if (lat !== 4) begin failures++; $display("[TB] FAIL u13x11_lat got=%0d exp=4", lat); end
        checks++; if (p !== 8'h8F) begin failures++; $display("[TB] FAIL u13x11_prod got=%h exp=8f", p); end
        checks++; if (bc !== 4) begin failures++; $display("[TB] FAIL u13x11_busy got=%0d exp=4", bc); end
        checks++; if (ov !== 0) begin failures++; $display("[TB] FAIL u13x11_overlap got=%0d exp=0", ov); end
        @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL valid_one_cycle got=%b exp=0", valid); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (prod !== 8'h8F) begin failures++; $display("[TB] FAIL prod_hold got=%h exp=8f", prod); end
        do_mult(1'b0, 4'd13, 4'd5, 1'b0, lat, p, bc, ov);
        checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL u13x5_lat got=%0d exp=3", lat); end
        checks++; if (p !== 8'h41) begin failures++; $display("[TB] FAIL u13x5_prod got=%h exp=41", p); end
        do_mult(1'b0, 4'd15, 4'd15, 1'b0, lat, p, bc, ov);
        checks++; if (p !== 8'hE1) begin failures++; $display("[TB] FAIL u15x15_prod got=%h exp=e1", p); end
    endtask

    task automatic test_signed();
        int lat, bc, ov;
        logic [7:0] p;
        do_mult(1'b0, 4'hD, 4'h5, 1'b1, lat, p, bc, ov);
        checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL sm3x5_lat got=%0d exp=3", lat); end
        checks++; if (p !== 8'hF1) begin failures++; $display("[TB] FAIL sm3x5_prod got=%h exp=f1", p); end
        do_mult(1'b0, 4'h8, 4'h8, 1'b1, lat, p, bc, ov);
        checks++; if (lat !== 4) begin failures++; $display("[TB] FAIL sm8xm8_lat got=%0d exp=4", lat); end
        checks++; if (p !== 8'h40) begin failures++; $display("[TB] FAIL sm8xm8_prod got=%h exp=40", p); end
        do_mult(1'b0, 4'h7, 4'hF, 1'b1, lat, p, bc, ov);
        checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL s7xm1_lat got=%0d exp=1", lat); end
        checks++; if (p !== 8'hF9) begin failures++; $display("[TB] FAIL s7xm1_prod got=%h exp=f9", p); end
        do_mult(1'b0, 4'h8, 4'h7, 1'b1, lat, p, bc, ov);
        checks++; if (p !== 8'hC8) begin failures++; $display("[TB] FAIL sm8x7_prod got=%h exp=c8", p); end
    endtask

    task automatic test_zero();
        int lat, bc, ov;
        logic [7:0] p;
        do_mult(1'b0, 4'd9, 4'd0, 1'b0, lat, p, bc, ov);
        checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL z9x0_lat got=%0d exp=1", lat); end
        checks++; if (p !== 8'h00) begin failures++; $display("[TB] FAIL z9x0_prod got=%h exp=00", p); end
        checks++; if (bc !== 1) begin failures++; $display("[TB] FAIL z9x0_busy got=%0d exp=1", bc); end
        do_mult(1'b0, 4'd0, 4'd15, 1'b0, lat, p, bc, ov);
        checks++; if (lat !== 4) begin failures++; $display("[TB] FAIL z0x15_lat got=%0d exp=4", lat); end
        checks++; if (p !== 8'h00) begin failures++; $display("[TB] FAIL z0x15_prod got=%h exp=00", p); end
    endtask

    task automatic test_back_to_back();
        int first_at, second_at, extra;
        logic [7:0] first_p, second_p;
        first_at = 0; second_at = 0; extra = 0;
        first_p = '0; second_p = '0;
        @(negedge clk);
        a = 4'd13; b = 4'd11; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 4'd2; b = 4'd3;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) begin
                checks++; if (prod !== 8'h8F) begin failures++; $display("[TB] FAIL b2b_prod_in_run got=%h exp=8f", prod); end
                start = 1'b0;
            end
            if (valid && first_at == 0) begin first_at = i; first_p = prod; end
            else if (valid && second_at == 0) begin second_at = i; second_p = prod; end
            else if (valid) extra++;
        end
        checks++; if (first_at !== 4) begin failures++; $display("[TB] FAIL b2b_first_at got=%0d exp=4", first_at); end
        checks++; if (first_p !== 8'h8F) begin failures++; $display("[TB] FAIL b2b_first_prod got=%h exp=8f", first_p); end
        checks++; if (second_at !== 7) begin failures++; $display("[TB] FAIL b2b_second_at got=%0d exp=7", second_at); end
        checks++; if (second_p !== 8'h06) begin failures++; $display("[TB] FAIL b2b_second_prod got=%h exp=06", second_p); end
        checks++; if (extra !== 0) begin failures++; $display("[TB] FAIL b2b_no_queue got=%0d exp=0", extra); end
        checks++; if (prod !== 8'h06) begin failures++; $display("[TB] FAIL b2b_prod_hold got=%h exp=06", prod); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, ov;
        logic [7:0] p;
        @(negedge clk);
        a = 4'd15; b = 4'd15; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (prod !== 8'h00) begin failures++; $display("[TB] FAIL midrst_prod got=%h exp=00", prod); end
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid got=%b exp=0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_no_result got=%b exp=0", valid); end
        do_mult(1'b0, 4'd15, 4'd15, 1'b0, lat, p, bc, ov);
        checks++; if (lat !== 4) begin failures++; $display("[TB] FAIL midrst_next_lat got=%0d exp=4", lat); end
        checks++; if (p !== 8'hE1) begin failures++; $display("[TB] FAIL midrst_next_prod got=%h exp=e1", p); end
    endtask

    task automatic test_early_term_off();
        int lat, bc, ov;
        logic [7:0] p;
        do_mult(1'b1, 4'd3, 4'd1, 1'b0, lat, p, bc, ov);
        checks++; if (lat !== 4) begin failures++; $display("[TB] FAIL full3x1_lat got=%0d exp=4", lat); end
        checks++; if (p !== 8'h03) begin failures++; $display("[TB] FAIL full3x1_prod got=%h exp=03", p); end
        checks++; if (bc !== 4) begin failures++; $display("[TB] FAIL full3x1_busy got=%0d exp=4", bc); end
        do_mult(1'b1, 4'hF, 4'hF, 1'b1, lat, p, bc, ov);
        checks++; if (lat !== 4) begin failures++; $display("[TB] FAIL fullm1xm1_lat got=%0d exp=4", lat); end
        checks++; if (p !== 8'h01) begin failures++; $display("[TB] FAIL fullm1xm1_prod got=%h exp=01", p); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_early_term_off();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter EARLY_TERM, default 1; 1 stops iterating when the remaining multiplier is zero, 0 always iterates WIDTH cycles.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin a multiply.
REQ-006 SHALL have port signed_mode, input, 1; 1 treats a and b as two's complement, 0 as unsigned.
REQ-007 SHALL have port a, input, WIDTH, multiplicand.
REQ-008 SHALL have port b, input, WIDTH, multiplier.
REQ-009 SHALL have port prod, output, 2*WIDTH, registered product.
REQ-010 SHALL have port valid, output, 1, single-cycle result strobe.
REQ-011 SHALL have port busy, output, 1, high while in RUN.

Function
REQ-012 SHALL implement FSM with states IDLE, RUN and DONE.
REQ-013 Start SHALL be accepted only in IDLE or DONE; a, b and signed_mode are captured on the accepting edge, and later input changes are ignored until the next acceptance.
REQ-014 On acceptance, the block SHALL load |a| and |b| as WIDTH-bit unsigned magnitudes, record neg = signed_mode & (a[W-1] ^ b[W-1]), and clear the accumulator and iteration counter.
REQ-015 Magnitudes SHALL use two's-complement negation when signed_mode=1 and the sign bit is set; -2^(W-1) SHALL map to 2^(W-1), which is representable unsigned.
REQ-016 Each RUN cycle SHALL add the multiplicand (2W-bit, left-shifted by the iteration count) to the accumulator if multiplier LSB=1, then shift the multiplier right by 1 and increment the counter.
REQ-017 RUN to DONE SHALL occur when the counter reaches WIDTH; with EARLY_TERM=1 it SHALL also occur when the post-shift multiplier is zero.
REQ-018 When the captured |b| is zero and EARLY_TERM=1, IDLE/DONE SHALL still pass through exactly one RUN cycle (uniform path).
REQ-019 Latency from accepting edge k to the valid cycle SHALL be L = 1 + msb(|b|) edges (msb(0)=0) when EARLY_TERM=1, and L = WIDTH when EARLY_TERM=0.
REQ-020 On the edge entering DONE, prod SHALL load the accumulator, two's-complement negated if neg=1, and valid SHALL be 1 for exactly that DONE cycle.
REQ-021 prod SHALL hold its value until the next DONE entry or reset; it SHALL NOT change during RUN.
REQ-022 DONE SHALL go to IDLE if start=0; if start=1 it SHALL accept and go to RUN (back-to-back operation).
REQ-023 start asserted during RUN SHALL be ignored and SHALL NOT be queued.
REQ-024 busy SHALL equal (state==RUN); valid and busy SHALL never both be 1.
REQ-025 The signed result SHALL be exact within 2*WIDTH bits for all operand pairs; the unsigned result SHALL be exact for all operand pairs.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, prod=0, valid=0, busy=0, and clear the accumulator, counter and operand registers, including in mid-RUN and in DONE.
REQ-027 reset SHALL take priority over start on the same edge; the first acceptance is possible on the edge after reset deasserts.

Structure
REQ-028 Shared package mult_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-029 Sub-module sam_datapath SHALL hold the operand, accumulator and counter registers and the add/shift/negate logic; shift_add_mult SHALL hold the FSM and instantiate it.

Verification (WIDTH=4, EARLY_TERM=1 unless stated)
REQ-030 Unsigned: a=13, b=11, start at edge k -> valid at k+4, prod=8'h8F, busy high for 4 cycles.
REQ-031 Signed: a=4'hD (-3), b=4'h5 -> prod=8'hF1 (-15) at k+3; a=4'h8, b=4'h8 (-8*-8) -> prod=8'h40 at k+4.
REQ-032 Zero: a=9, b=0 -> prod=0 at k+1; a=0, b=15 -> prod=0 at k+4.
REQ-033 Handshake: start held during RUN -> no second result; start=1 in DONE with a=2, b=3 -> second valid 2 edges later, prod=8'h06.
REQ-034 Reset mid-RUN: a=15, b=15, reset at k+2 -> prod=0, valid=0, busy=0, IDLE; the next start gives a correct result.
REQ-035 EARLY_TERM=0: a=3, b=1 -> valid at k+4, prod=8'h03.
